// File: rtl/mem_uart_dump_pkg.sv
// Shared definitions for the RAM <-> UART streaming blocks: FSM encoding,
// UART byte width and RAM geometry defaults common with the collector.
package mem_uart_dump_pkg;

    localparam int BYTE_W     = 8;
    localparam int RAM_ADDR_W = 14;
    localparam int RAM_DATA_W = 14;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_WAIT_MEM = 3'd2,
        S_SEND     = 3'd3,
        S_ACK      = 3'd4,
        S_DRAIN    = 3'd5
    } dump_state_t;

    // Byte k of a (zero-extended) word, LSB byte first.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [2*BYTE_W-1:0] word,
                                                    input logic idx);
        return idx ? word[2*BYTE_W-1:BYTE_W] : word[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/mem_uart_dump.sv
// Streams NUM_DATA RAM words to the UART TX byte interface, LSB byte first.
// One RAM read per word, then SEND/ACK/DRAIN handshake per byte.
module mem_uart_dump import mem_uart_dump_pkg::*; #(
    parameter int NUM_DATA       = 40,
    parameter int ADDR_W         = RAM_ADDR_W,
    parameter int DATA_W         = RAM_DATA_W,
    parameter int BYTES_PER_WORD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sent_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_DATA - 1);
    localparam logic              LAST_BYTE = 1'(BYTES_PER_WORD - 1);

    dump_state_t         state, state_n;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   word_reg;
    logic                byte_idx;
    logic [BYTE_W-1:0]   tx_data_q;
    logic                start_prev;
    logic [2*BYTE_W-1:0] word_ext;
    logic [BYTE_W-1:0]   byte_sel;
    logic                start_edge, last_byte, last_word, drain_done;

    assign start_edge = start & ~start_prev;
    assign last_byte  = (byte_idx == LAST_BYTE);
    assign last_word  = (addr == LAST_ADDR);
    assign drain_done = (state == S_DRAIN) && !tx_busy;
    assign word_ext   = (2*BYTE_W)'(word_reg);
    assign byte_sel   = word_byte(word_ext, byte_idx);

    assign mem_rd_addr = addr;
    // Present the new byte in the tx_start cycle itself, then hold it until the next SEND.
    assign tx_data     = tx_start ? byte_sel : tx_data_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        mem_rd_en = 1'b0;
        tx_start  = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:     if (start_edge && !busy) state_n = S_READ;
            S_READ: begin
                mem_rd_en = 1'b1;
                state_n   = S_WAIT_MEM;
            end
            S_WAIT_MEM: state_n = S_SEND;
            S_SEND: if (!tx_busy) begin
                tx_start = 1'b1;
                state_n  = S_ACK;
            end
            S_ACK:      state_n = S_DRAIN;
            S_DRAIN: if (!tx_busy) begin
                if (!last_byte)     state_n = S_SEND;
                else if (last_word) begin
                    done    = 1'b1;
                    state_n = S_IDLE;
                end
                else                state_n = S_READ;
            end
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            sent_count <= '0;
            busy       <= 1'b0;
            start_prev <= 1'b0;
            word_reg   <= '0;
            byte_idx   <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            start_prev <= start;
            if (state == S_IDLE && start_edge && !busy) begin
                addr       <= '0;
                sent_count <= '0;
                busy       <= 1'b1;
            end
            if (state == S_WAIT_MEM) begin
                word_reg <= mem_rd_data;
                byte_idx <= 1'b0;
            end
            if (tx_start)
                tx_data_q <= byte_sel;
            if (drain_done) begin
                if (!last_byte) begin
                    byte_idx <= byte_idx + 1'b1;
                end else begin
                    sent_count <= sent_count + 1'b1;
                    if (last_word) busy <= 1'b0;
                    else           addr <= addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_uart_dump.sv
// Scoreboard bench for mem_uart_dump: a 4-word/2-byte instance with a UART
// busy model, plus a 1-word/1-byte instance driven by hand.
module tb_mem_uart_dump;

    localparam int ND       = 4;
    localparam int AW       = 14;
    localparam int DW       = 14;
    localparam int BUSY_CYC = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start;
    logic          mem_rd_en, tx_start, tx_busy, busy, done;
    logic [AW-1:0] mem_rd_addr, sent_count;
    logic [DW-1:0] mem_rd_data = '0;
    logic [7:0]    tx_data;

    logic          start1, tx_busy1;
    logic          mem_rd_en1, tx_start1, busy1, done1;
    logic [AW-1:0] mem_rd_addr1, sent_count1;
    logic [DW-1:0] mem_rd_data1 = '0;
    logic [7:0]    tx_data1;

    mem_uart_dump #(.NUM_DATA(ND), .ADDR_W(AW), .DATA_W(DW), .BYTES_PER_WORD(2)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .busy(busy), .done(done), .sent_count(sent_count)
    );

    mem_uart_dump #(.NUM_DATA(1), .ADDR_W(AW), .DATA_W(DW), .BYTES_PER_WORD(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .mem_rd_en(mem_rd_en1), .mem_rd_addr(mem_rd_addr1), .mem_rd_data(mem_rd_data1),
        .tx_data(tx_data1), .tx_start(tx_start1), .tx_busy(tx_busy1),
        .busy(busy1), .done(done1), .sent_count(sent_count1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] ram [ND];
    logic [7:0]    sb [$];

    // UART model: busy rises the cycle after tx_start, stays up BUSY_CYC cycles.
    logic          hold = 1'b0, mdl_busy = 1'b0, pend = 1'b0;
    int            bcnt = 0;
    assign tx_busy = mdl_busy | hold;

    int            n_rd = 0, n_txs = 0, n_done = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [7:0]    held = '0;
    logic          prev_tx_busy = 1'b0, prev_busy = 1'b0, prev_done = 1'b0, prev_rst = 1'b1;

    // Inputs change at negedge; outputs are sampled 1 time unit later.
    always @(negedge clk) begin
        if (pend) begin
            mdl_busy = 1'b1;
            bcnt     = BUSY_CYC;
            pend     = 1'b0;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) mdl_busy = 1'b0;
        end
        #1;
        if (mem_rd_en) begin
            n_rd++;
            chk("rd_addr", 32'(mem_rd_addr), 32'(exp_addr));
            mem_rd_data = ram[mem_rd_addr[1:0]];
            exp_addr    = exp_addr + 1'b1;
        end
        if (tx_start) begin
            n_txs++;
            pend = 1'b1;
            chk("tx_start_while_busy", 32'(tx_busy), 0);
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else                chk("tx_data", 32'(tx_data), 32'(sb.pop_front()));
            held = tx_data;
        end else if (rst) begin
            held = 8'h00;
        end else if (tx_busy && prev_tx_busy) begin
            chk("tx_data_hold", 32'(tx_data), 32'(held));
        end
        if (done) begin
            n_done++;
            chk("done_while_busy", 32'(busy), 1);
        end
        if (prev_done) chk("sent_count_at_done", 32'(sent_count), ND);
        if (prev_busy && !busy && !rst && !prev_rst)
            chk("busy_fall_only_after_done", 32'(prev_done), 1);
        prev_tx_busy = tx_busy;
        prev_busy    = busy;
        prev_done    = done;
        prev_rst     = rst;
    end

    int n_rd1 = 0, n_txs1 = 0;
    always @(negedge clk) begin
        #1;
        if (mem_rd_en1) begin
            n_rd1++;
            mem_rd_data1 = 14'h00A5;
        end
        if (tx_start1) n_txs1++;
    end

    task automatic push_run();
        for (int w = 0; w < ND; w++) begin
            logic [15:0] wd;
            wd = 16'(ram[w]);
            sb.push_back(wd[7:0]);
            sb.push_back(wd[15:8]);
        end
        exp_addr = '0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_txs(input int target);
        int t;
        t = 0;
        while (n_txs < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (n_txs < target) chk("tx_start_timeout", 32'(n_txs), 32'(target));
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (n_done == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (n_done == d0) chk("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},     32'(busy),        0);
        chk({tag, "_done"},     32'(done),        0);
        chk({tag, "_tx_start"}, 32'(tx_start),    0);
        chk({tag, "_rd_en"},    32'(mem_rd_en),   0);
        chk({tag, "_rd_addr"},  32'(mem_rd_addr), 0);
        chk({tag, "_tx_data"},  32'(tx_data),     0);
        chk({tag, "_sent"},     32'(sent_count),  0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, r0, t0, t;
        ram      = '{14'h1234, 14'h0001, 14'h3FFF, 14'h0ABC};
        rst      = 1'b1;
        start    = 1'b0;
        start1   = 1'b0;
        tx_busy1 = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk_idle("reset");
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        // Run 1: plain dump, extra start pulse mid-run, start held high through done.
        d0 = n_done; r0 = n_rd; t0 = n_txs;
        push_run();
        pulse_start();
        wait_txs(t0 + 2);
        pulse_start();
        wait_txs(t0 + 7);
        @(negedge clk) start = 1'b1;
        wait_done(d0);
        repeat (100) @(negedge clk);
        #1;
        chk("run1_done_count", 32'(n_done - d0), 1);
        chk("run1_rd_count",   32'(n_rd - r0),   ND);
        chk("run1_tx_count",   32'(n_txs - t0),  2*ND);
        chk("run1_sb_empty",   32'(sb.size()),   0);
        chk("run1_idle_busy",  32'(busy),        0);
        chk("run1_sent_hold",  32'(sent_count),  ND);
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);

        // Run 2: UART already busy at start, first byte must wait in SEND.
        @(negedge clk) hold = 1'b1;
        d0 = n_done; r0 = n_rd; t0 = n_txs;
        push_run();
        pulse_start();
        repeat (50) @(negedge clk);
        #1;
        chk("hold_no_tx_start", 32'(n_txs - t0), 0);
        chk("hold_busy",        32'(busy),       1);
        chk("hold_one_read",    32'(n_rd - r0),  1);
        @(negedge clk) hold = 1'b0;
        wait_done(d0);
        chk("run2_rd_count", 32'(n_rd - r0),  ND);
        chk("run2_tx_count", 32'(n_txs - t0), 2*ND);
        chk("run2_sb_empty", 32'(sb.size()),  0);
        repeat (3) @(negedge clk);

        // Run 3: reset while the third byte drains, then restart from address 0.
        t0 = n_txs;
        push_run();
        pulse_start();
        wait_txs(t0 + 3);
        t = 0;
        while (!tx_busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("pre_rst_sent", 32'(sent_count), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 chk_idle("mid_rst");
        @(negedge clk) rst = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        #1 chk_idle("post_rst");
        d0 = n_done; r0 = n_rd; t0 = n_txs;
        push_run();
        pulse_start();
        wait_done(d0);
        chk("run3_rd_count", 32'(n_rd - r0),  ND);
        chk("run3_tx_count", 32'(n_txs - t0), 2*ND);
        chk("run3_sb_empty", 32'(sb.size()),  0);

        // Single word, single byte instance.
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            #1;
            if (tx_start1) break;
        end
        chk("b_tx_start", 32'(tx_start1),    1);
        chk("b_tx_data",  32'(tx_data1),     32'h00A5);
        chk("b_rd_addr",  32'(mem_rd_addr1), 0);
        @(negedge clk) tx_busy1 = 1'b1;
        repeat (10) @(negedge clk);
        tx_busy1 = 1'b0;
        // tx_busy is driven at negedge here, so DRAIN sees it low within this cycle.
        #1;
        chk("b_done",      32'(done1), 1);
        chk("b_done_busy", 32'(busy1), 1);
        @(negedge clk);
        #1;
        chk("b_done_pulse", 32'(done1),       0);
        chk("b_idle_busy",  32'(busy1),       0);
        chk("b_sent",       32'(sent_count1), 1);
        chk("b_rd_count",   32'(n_rd1),       1);
        chk("b_tx_count",   32'(n_txs1),      1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
